// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster 8-bit pixel stream into 3x3 windows for the matrix multiplier,
// pulsing mm_start per window and stalling the stream until mm_done. Option: CONV_WINDOW_STRIDE2_EN.
module conv_window_gen #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               pix_in,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    output logic                     pix_ready,
    output logic [8:0][7:0]          window,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     mm_start,
    input  logic                     mm_done,
    output logic                     frame_done
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [8:0][7:0]  shift_q, shift_d;
    logic [8:0][7:0]  window_q, window_d;
    logic [RW-1:0]    win_row_q, win_row_d;
    logic [CW-1:0]    win_col_q, win_col_d;
    logic             last_q, last_d;
    logic             frame_done_q, frame_done_d;

    logic [7:0]       lb_top_q [IMG_W];
    logic [7:0]       lb_mid_q [IMG_W];

    logic             accept;
    logic [RW-1:0]    cur_row;
    logic [CW-1:0]    cur_col;
    logic [7:0]       top_pix;
    logic [7:0]       mid_pix;
    logic             win_ok;
    logic             at_final;

    assign accept   = pix_valid && (state_q == S_FILL);
    assign cur_row  = pix_sof ? '0 : row_q;
    assign cur_col  = pix_sof ? '0 : col_q;
    assign top_pix  = lb_top_q[cur_col];
    assign mid_pix  = lb_mid_q[cur_col];
    assign at_final = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

`ifdef CONV_WINDOW_STRIDE2_EN
    // row-2 and col-2 share parity with row and col
    assign win_ok = (cur_row >= RW'(2)) && (cur_col >= CW'(2)) && !cur_row[0] && !cur_col[0];
`else
    assign win_ok = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
`endif

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        shift_d      = shift_q;
        window_d     = window_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        last_d       = last_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_FILL: begin
                if (pix_valid) begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        shift_d[r*3 + 0] = shift_q[r*3 + 1];
                        shift_d[r*3 + 1] = shift_q[r*3 + 2];
                    end
                    shift_d[2] = top_pix;
                    shift_d[5] = mid_pix;
                    shift_d[8] = pix_in;

                    if (cur_col == COL_LAST) begin
                        col_d = '0;
                        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
                    end else begin
                        col_d = cur_col + CW'(1);
                        row_d = cur_row;
                    end

                    if (win_ok) begin
                        window_d  = shift_d;
                        win_row_d = cur_row - RW'(2);
                        win_col_d = cur_col - CW'(2);
                        last_d    = at_final;
                        state_d   = S_ISSUE;
                    end
`ifdef CONV_WINDOW_STRIDE2_EN
                    else if (at_final) begin
                        // frame ends on a skipped position: nothing left to wait for
                        frame_done_d = 1'b1;
                    end
`endif
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mm_done) begin
                    state_d      = S_FILL;
                    frame_done_d = last_q;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FILL;
            row_q        <= '0;
            col_q        <= '0;
            shift_q      <= '0;
            window_q     <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            shift_q      <= shift_d;
            window_q     <= window_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // line buffers hold pixel data only and are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top_q[cur_col] <= mid_pix;
            lb_mid_q[cur_col] <= pix_in;
        end
    end

    assign pix_ready  = (state_q == S_FILL);
    assign mm_start   = (state_q == S_ISSUE);
    assign window     = window_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: directed frames against a window table plus
// randomized frames against an image-array reference model, with a latency-programmable multiplier stub.
`timescale 1ns/1ps
module tb_conv_window_gen;

`ifdef CONV_WINDOW_STRIDE2_EN
    localparam int unsigned W = 5;
    localparam int unsigned H = 5;
    localparam bit STRIDE2 = 1'b1;
`else
    localparam int unsigned W = 4;
    localparam int unsigned H = 4;
    localparam bit STRIDE2 = 1'b0;
`endif
    localparam int unsigned NWIN = STRIDE2 ? ((H - 1) / 2) * ((W - 1) / 2) : (H - 2) * (W - 2);

    logic                   clk;
    logic                   reset_n;
    logic [7:0]             pix_in;
    logic                   pix_valid;
    logic                   pix_sof;
    logic                   pix_ready;
    logic [8:0][7:0]        window;
    logic [$clog2(H)-1:0]   win_row;
    logic [$clog2(W)-1:0]   win_col;
    logic                   mm_start;
    logic                   mm_done = 1'b1;
    logic                   frame_done;

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .window     (window),
        .win_row    (win_row),
        .win_col    (win_col),
        .mm_start   (mm_start),
        .mm_done    (mm_done),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // multiplier stub: done drops on start, rises done_lat cycles later
    int unsigned done_lat = 37;
    int unsigned done_cnt = 0;
    always @(posedge clk) begin
        if (!reset_n) begin
            done_cnt <= 0;
        end else if (mm_start) begin
            mm_done  <= 1'b0;
            done_cnt <= done_lat;
        end else if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) mm_done <= 1'b1;
        end
    end

    typedef struct {
        int unsigned     row;
        int unsigned     col;
        int unsigned     trig;
        logic [8:0][7:0] win;
    } win_rec_t;

    win_rec_t    cap[$];
    logic [7:0]  img [H][W];
    int          ph = 0;            // 0 accepting, 1 issuing, 2 waiting on multiplier
    logic        fd_exp = 1'b0;
    int unsigned pr = 0, pc = 0;
    logic [8:0][7:0] hold_win = '0;
    int unsigned hold_r = 0, hold_c = 0;
    bit          hold_last = 1'b0;
    int unsigned last_pix = 0;
    int unsigned fd_seen = 0;

    always @(negedge clk) begin
        int unsigned r, c;
        int          nph;
        logic        fd_next;
        win_rec_t    rec;
        if (!reset_n) begin
            check("rst_pix_ready", pix_ready, 1'b1);
            check("rst_mm_start", mm_start, 1'b0);
            check("rst_frame_done", frame_done, 1'b0);
            check("rst_window", window, '0);
            check("rst_win_row", win_row, '0);
            check("rst_win_col", win_col, '0);
            ph = 0; fd_exp = 1'b0; pr = 0; pc = 0;
            hold_win = '0; hold_r = 0; hold_c = 0; hold_last = 1'b0;
        end else begin
            check("pix_ready", pix_ready, ph == 0);
            check("mm_start", mm_start, ph == 1);
            check("frame_done", frame_done, fd_exp);
            check("window", window, hold_win);
            check("win_row", win_row, hold_r);
            check("win_col", win_col, hold_c);
            if (frame_done) fd_seen++;
            if (ph == 1) begin
                rec.row = win_row; rec.col = win_col; rec.trig = last_pix; rec.win = window;
                cap.push_back(rec);
            end
            nph = ph;
            fd_next = 1'b0;
            if (ph == 0 && pix_valid) begin
                r = pix_sof ? 0 : pr;
                c = pix_sof ? 0 : pc;
                img[r][c] = pix_in;
                last_pix  = pix_in;
                if (r >= 2 && c >= 2 && (!STRIDE2 || ((r - 2) % 2 == 0 && (c - 2) % 2 == 0))) begin
                    for (int unsigned k = 0; k < 9; k++) hold_win[k] = img[r - 2 + k / 3][c - 2 + k % 3];
                    hold_r = r - 2; hold_c = c - 2;
                    hold_last = (r == H - 1) && (c == W - 1);
                    nph = 1;
                end else if (r == H - 1 && c == W - 1) begin
                    fd_next = 1'b1;
                end
                if (c == W - 1) begin
                    pc = 0;
                    pr = (r == H - 1) ? 0 : r + 1;
                end else begin
                    pc = c + 1;
                    pr = r;
                end
            end else if (ph == 1) begin
                nph = 2;
            end else if (ph == 2 && mm_done) begin
                nph = 0;
                fd_next = hold_last;
            end
            ph = nph;
            fd_exp = fd_next;
        end
    end

    task automatic send_pix(input logic [7:0] v, input logic sof);
        int unsigned n;
        n = 0;
        pix_in = v; pix_valid = 1'b1; pix_sof = sof;
        @(negedge clk);
        while (!pix_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", n < 5000, 1'b1);
        @(posedge clk); #2;
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!pix_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_bound", n < 5000, 1'b1);
        @(posedge clk); #2;
    endtask

    task automatic send_frame(input int unsigned base);
        for (int unsigned i = 0; i < W * H; i++) send_pix(8'(base + i), i == 0);
        wait_idle();
    endtask

    function automatic win_rec_t mkrec(input int unsigned row, col, trig,
                                       input int unsigned a0, a1, a2, a3, a4, a5, a6, a7, a8);
        win_rec_t x;
        x.row = row; x.col = col; x.trig = trig;
        x.win = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        return x;
    endfunction

    win_rec_t tbl[NWIN];

    task automatic cmp_table(input string tag);
        check({tag, "_count"}, cap.size(), NWIN);
        for (int unsigned i = 0; i < NWIN; i++) begin
            if (i < cap.size()) begin
                check($sformatf("%s_row%0d", tag, i), cap[i].row, tbl[i].row);
                check($sformatf("%s_col%0d", tag, i), cap[i].col, tbl[i].col);
                check($sformatf("%s_trig%0d", tag, i), cap[i].trig, tbl[i].trig);
                check($sformatf("%s_win%0d", tag, i), cap[i].win, tbl[i].win);
            end
        end
    endtask

    initial begin
        int unsigned fd0;
        bit clean;
`ifdef CONV_WINDOW_STRIDE2_EN
        tbl[0] = mkrec(0, 0, 13, 1, 2, 3, 6, 7, 8, 11, 12, 13);
        tbl[1] = mkrec(0, 2, 15, 3, 4, 5, 8, 9, 10, 13, 14, 15);
        tbl[2] = mkrec(2, 0, 23, 11, 12, 13, 16, 17, 18, 21, 22, 23);
        tbl[3] = mkrec(2, 2, 25, 13, 14, 15, 18, 19, 20, 23, 24, 25);
`else
        tbl[0] = mkrec(0, 0, 11, 1, 2, 3, 5, 6, 7, 9, 10, 11);
        tbl[1] = mkrec(0, 1, 12, 2, 3, 4, 6, 7, 8, 10, 11, 12);
        tbl[2] = mkrec(1, 0, 15, 5, 6, 7, 9, 10, 11, 13, 14, 15);
        tbl[3] = mkrec(1, 1, 16, 6, 7, 8, 10, 11, 12, 14, 15, 16);
`endif
        reset_n = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #2;

        // frame 1..W*H, valid held, 37-cycle multiplier
        done_lat = 37;
        cap.delete();
        fd0 = fd_seen;
        send_frame(1);
        cmp_table("frame1");
        check("frame1_done_pulses", fd_seen - fd0, 1);

        // reset three cycles into the first wait
        done_lat = 1000;
        cap.delete();
        for (int unsigned i = 0; i < 2 * W + 3; i++) send_pix(8'(i + 1), i == 0);
        repeat (3) begin @(posedge clk); #2; end
        check("prereset_issues", cap.size(), 1);
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", pix_ready, 1'b1);
        @(posedge clk); #2;
        done_lat = 37;
        cap.delete();
        fd0 = fd_seen;
        send_frame(1);
        cmp_table("after_reset");
        check("after_reset_done_pulses", fd_seen - fd0, 1);

        // sof on the 6th pixel abandons the partial frame
        cap.delete();
        fd0 = fd_seen;
        for (int unsigned i = 0; i < 5; i++) send_pix(8'(200 + i), i == 0);
        send_frame(1);
        cmp_table("sof6");
        if (cap.size() > 0) begin
            clean = 1'b1;
            for (int unsigned k = 0; k < 9; k++) if (cap[0].win[k] >= 8'd200) clean = 1'b0;
            check("sof6_post_sof_only", clean, 1'b1);
        end
        check("sof6_done_pulses", fd_seen - fd0, 1);

        // randomized frames checked by the reference model
        for (int f = 0; f < 4; f++) begin
            done_lat = $urandom_range(1, 6);
            cap.delete();
            fd0 = fd_seen;
            for (int unsigned i = 0; i < W * H; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
                send_pix(8'($urandom_range(0, 255)), i == 0);
            end
            wait_idle();
            check($sformatf("rand%0d_count", f), cap.size(), NWIN);
            check($sformatf("rand%0d_done_pulses", f), fd_seen - fd0, 1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
